datapath_mc: RTL and testbench

DATAPATH_MC -- requirements
Module: datapath_mc

---
 rtl/datapath_mc_if.sv | 14 +
 rtl/datapath_mc.sv | 215 +++++++++++++++++++++
 tb/tb_datapath_mc.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/datapath_mc_if.sv
// datapath_mc_if: memory request/acknowledge bus between datapath_mc and its memory
interface datapath_mc_if #(
    parameter int NBITS = 32
);
    logic             mem_req;
    logic             mem_we;
    logic [NBITS-3:0] Address;
    logic [NBITS-1:0] WriteData;
    logic [NBITS-1:0] ReadData;
    logic             mem_ack;

    modport master (output mem_req, mem_we, Address, WriteData, input ReadData, mem_ack);
    modport slave  (input mem_req, mem_we, Address, WriteData, output ReadData, mem_ack);
endinterface

// File: rtl/datapath_mc.sv
// datapath_mc: multi-cycle datapath (register file, ALU, word memory port);
// define DATAPATH_MUL_EN to add an iterative shift-add multiplier on ALUControl=10
module datapath_mc #(
    parameter int NBITS      = 32,
    parameter int NREGS      = 32,
    parameter int WIDTH_ALUF = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [$clog2(NREGS)-1:0] RS1,
    input  logic [$clog2(NREGS)-1:0] RS2,
    input  logic [$clog2(NREGS)-1:0] RD,
    input  logic [NBITS-1:0]         IMM,
    input  logic [WIDTH_ALUF-1:0]    ALUControl,
    input  logic                     ALUSrc,
    input  logic                     MemtoReg,
    input  logic                     RegWrite,
    input  logic                     MemRead,
    input  logic                     MemWrite,
    input  logic                     link,
    input  logic [NBITS-1:0]         pclink,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic                     Zero,
    output logic                     Neg,
    output logic                     Carry,
    output logic [NBITS-1:0]         PCReg,
    datapath_mc_if.master            mem
);
    localparam int RW = $clog2(NREGS);
    localparam int SW = $clog2(NBITS);

`ifdef DATAPATH_MUL_EN
    typedef enum logic [2:0] {IDLE, EXEC, MUL, MEM, WB} state_t;
`else
    typedef enum logic [2:0] {IDLE, EXEC, MEM, WB} state_t;
`endif

    state_t state, nstate;

    logic [NBITS-1:0]      regs [NREGS];
    logic [NBITS-1:0]      rdata1, rdata2, wb_data;
    logic [NBITS-1:0]      src_a, src_b, sdata, pcl_l, alu_res, ldata;
    logic [WIDTH_ALUF-1:0] op_l;
    logic [RW-1:0]         rd_l;
    logic                  m2r_l, rw_l, mr_l, mw_l, link_l, errf;
    logic [NBITS:0]        sum;
    logic [NBITS-1:0]      alu_y;
    logic                  alu_c, geu, mem_op, misal, is_mul;
    logic [SW-1:0]         sh;

    assign rdata1  = (RS1 == '0) ? '0 : regs[RS1];
    assign rdata2  = (RS2 == '0) ? '0 : regs[RS2];
    assign wb_data = link_l ? pcl_l : m2r_l ? ldata : alu_res;
    assign mem_op  = mr_l | mw_l;
    assign misal   = alu_y[1:0] != 2'b00;
    assign PCReg   = src_a;
    assign mem.Address   = alu_res[NBITS-1:2];
    assign mem.WriteData = sdata;

`ifdef DATAPATH_MUL_EN
    assign is_mul = int'(op_l) == 10;
`else
    assign is_mul = 1'b0;
`endif

    // ALU on the latched operands; unlisted codes fall back to ADD
    always_comb begin
        sum   = {1'b0, src_a} + {1'b0, src_b};
        geu   = src_a >= src_b;
        sh    = src_b[SW-1:0];
        alu_y = sum[NBITS-1:0];
        alu_c = sum[NBITS];
        case (int'(op_l))
            1: begin alu_y = src_a - src_b; alu_c = geu; end
            2: begin alu_y = src_a & src_b; alu_c = 1'b0; end
            3: begin alu_y = src_a | src_b; alu_c = 1'b0; end
            4: begin alu_y = src_a ^ src_b; alu_c = 1'b0; end
            5: begin alu_y = src_a << sh; alu_c = 1'b0; end
            6: begin alu_y = src_a >> sh; alu_c = 1'b0; end
            7: begin alu_y = $signed(src_a) >>> sh; alu_c = 1'b0; end
            8: begin alu_y = NBITS'($signed(src_a) < $signed(src_b)); alu_c = geu; end
            9: begin alu_y = NBITS'(!geu); alu_c = geu; end
            default: ;
        endcase
    end

`ifdef DATAPATH_MUL_EN
    logic [NBITS-1:0] mcand, mplier, acc, prod;
    logic [SW-1:0]    cnt;
    logic             mul_last;

    assign prod     = acc + (mplier[0] ? mcand : '0);
    assign mul_last = cnt == SW'(NBITS - 1);

    // shift-add multiplier: one multiplier bit per MUL cycle, low NBITS kept
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == EXEC) begin
            mcand  <= src_a;
            mplier <= src_b;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == MUL) begin
            acc    <= prod;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end
    end
`endif

    // state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nstate;
    end

    // next-state: misaligned memory ops skip MEM and finish with an error
    always_comb begin
        nstate = state;
        case (state)
            IDLE:    nstate = start ? EXEC : IDLE;
            EXEC:    nstate = is_mul ? EXEC : (mem_op && !misal) ? MEM : WB;
`ifdef DATAPATH_MUL_EN
            MUL:     nstate = mul_last ? WB : MUL;
`endif
            MEM:     nstate = mem.mem_ack ? WB : MEM;
            WB:      nstate = IDLE;
            default: nstate = IDLE;
        endcase
`ifdef DATAPATH_MUL_EN
        if (state == EXEC && is_mul) nstate = MUL;
`endif
    end

    // state-decoded outputs; a store wins when both MemRead and MemWrite are set
    always_comb begin
        busy        = state != IDLE;
        mem.mem_req = state == MEM;
        mem.mem_we  = state == MEM && mw_l;
    end

    // instruction latch, ALU result/flags, load capture and completion pulses
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            src_a   <= '0;
            src_b   <= '0;
            sdata   <= '0;
            pcl_l   <= '0;
            op_l    <= '0;
            rd_l    <= '0;
            m2r_l   <= 1'b0;
            rw_l    <= 1'b0;
            mr_l    <= 1'b0;
            mw_l    <= 1'b0;
            link_l  <= 1'b0;
            alu_res <= '0;
            ldata   <= '0;
            errf    <= 1'b0;
            Zero    <= 1'b0;
            Neg     <= 1'b0;
            Carry   <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                src_a  <= rdata1;
                src_b  <= ALUSrc ? IMM : rdata2;
                sdata  <= rdata2;
                pcl_l  <= pclink;
                op_l   <= ALUControl;
                rd_l   <= RD;
                m2r_l  <= MemtoReg;
                rw_l   <= RegWrite;
                mr_l   <= MemRead;
                mw_l   <= MemWrite;
                link_l <= link;
            end
            if (state == EXEC) errf <= mem_op && misal && !is_mul;
            if (state == EXEC && !is_mul) begin
                alu_res <= alu_y;
                Zero    <= alu_y == '0;
                Neg     <= alu_y[NBITS-1];
                Carry   <= alu_c;
            end
`ifdef DATAPATH_MUL_EN
            if (state == MUL && mul_last) begin
                alu_res <= prod;
                Zero    <= prod == '0;
                Neg     <= prod[NBITS-1];
                Carry   <= 1'b0;
            end
`endif
            if (state == MEM && mem.mem_ack && !mw_l) ldata <= mem.ReadData;
            done <= state == WB;
            err  <= state == WB && errf;
        end
    end

    // register file: written only in WB, never for x0 or a faulted op
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (state == WB && rw_l && rd_l != '0 && !errf) begin
            regs[rd_l] <= wb_data;
        end
    end
endmodule

// File: tb/tb_datapath_mc.sv
// tb_datapath_mc: directed and randomized checks of datapath_mc against a behavioural model
module tb_datapath_mc;
    localparam int NB = 32;
`ifdef DATAPATH_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    logic        clock = 1'b0, reset = 1'b1, start = 1'b0;
    logic [4:0]  RS1 = '0, RS2 = '0, RD = '0;
    logic [31:0] IMM = '0, pclink = '0;
    logic [3:0]  ALUControl = '0;
    logic        ALUSrc = 0, MemtoReg = 0, RegWrite = 0, MemRead = 0, MemWrite = 0, link = 0;
    logic        busy, done, err, Zero, Neg, Carry;
    logic [31:0] PCReg;

    datapath_mc_if #(.NBITS(NB)) bus ();

    datapath_mc dut (
        .clock(clock), .reset(reset), .start(start),
        .RS1(RS1), .RS2(RS2), .RD(RD), .IMM(IMM), .ALUControl(ALUControl),
        .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .link(link), .pclink(pclink),
        .busy(busy), .done(done), .err(err), .Zero(Zero), .Neg(Neg), .Carry(Carry),
        .PCReg(PCReg), .mem(bus)
    );

    always #5 clock = ~clock;

    logic [31:0] mregs [32];
    logic [31:0] mmem [64];
    logic [31:0] smem [64];
    int passes = 0, fails = 0, checks = 0;
    int lat, req_cycles, ack_wait, ack_cnt;
    bit addr_bad, wd_bad, we_bad, err_seen, exp_we;
    logic [29:0] exp_addr;
    logic [31:0] exp_wd, v;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input int code, input logic [31:0] a, input logic [31:0] b,
                                            output logic c);
        logic [32:0] s;
        logic [31:0] r;
        int sh;
        sh = int'(b[4:0]);
        c = 1'b0;
        case (code)
            1: begin r = a - b; c = a >= b; end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = a << sh;
            6: r = a >> sh;
            7: r = 32'($signed(a) >>> sh);
            8: begin r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; c = a >= b; end
            9: begin r = (a < b) ? 32'd1 : 32'd0; c = a >= b; end
            default: begin
                if (MUL_ON && code == 10) r = a * b;
                else begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32]; end
            end
        endcase
        return r;
    endfunction

    task automatic op(input logic [3:0] ctl, input int rs1, input int rs2, input int rd,
                      input logic [31:0] imm, input bit asrc, input bit m2r, input bit rw,
                      input bit mr, input bit mw, input bit lk, input logic [31:0] pcl);
        ALUControl = ctl;
        RS1 = 5'(rs1);
        RS2 = 5'(rs2);
        RD = 5'(rd);
        IMM = imm;
        ALUSrc = asrc;
        MemtoReg = m2r;
        RegWrite = rw;
        MemRead = mr;
        MemWrite = mw;
        link = lk;
        pclink = pcl;
    endtask

    // pulse start, then count cycles to done while acting as the memory slave
    task automatic run();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        lat = 0; req_cycles = 0; ack_cnt = 0;
        addr_bad = 0; wd_bad = 0; we_bad = 0;
        while (!done && lat < 300) begin
            @(posedge clock); #1;
            lat++;
            if (bus.mem_req) begin
                req_cycles++;
                if (bus.Address !== exp_addr) addr_bad = 1;
                if (bus.WriteData !== exp_wd) wd_bad = 1;
                if (bus.mem_we !== exp_we) we_bad = 1;
                if (ack_cnt == ack_wait) begin
                    bus.mem_ack = 1'b1;
                    bus.ReadData = smem[bus.Address[5:0]];
                    if (bus.mem_we) smem[bus.Address[5:0]] = bus.WriteData;
                end else begin
                    ack_cnt++;
                    bus.mem_ack = 1'b0;
                end
            end else begin
                bus.mem_ack = 1'b0;
            end
        end
        err_seen = err;
        check("done_seen", done, 1);
    endtask

    task automatic set_reg(input int r, input logic [31:0] val);
        op(0, 0, 0, r, 0, 1, 0, 1, 0, 0, 1, val);
        ack_wait = 0;
        run();
        if (r != 0) mregs[r] = val;
    endtask

    task automatic read_reg(input int r, output logic [31:0] val);
        op(0, r, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        ack_wait = 0;
        run();
        val = PCReg;
    endtask

    initial begin
        int code, rs1, rs2, rd, word;
        bit asrc, rw, lk, st;
        logic [31:0] a, b, imm, pcl, exp;
        logic c;
        for (int i = 0; i < 64; i++) begin
            smem[i] = (i * 32'h01010101) ^ 32'h5A5A0000;
            mmem[i] = smem[i];
        end
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        bus.mem_ack = 1'b0;
        bus.ReadData = '0;
        ack_wait = 0;
        exp_addr = '0; exp_wd = '0; exp_we = 0;

        #1 reset = 1'b0;
        #2;
        check("rst_busy", busy, 0);
        check("rst_pulses", {done, err}, 0);
        check("rst_bus", {bus.mem_req, bus.mem_we, bus.Address, bus.WriteData}, 0);
        check("rst_state", {Zero, Neg, Carry, PCReg}, 0);
        #9 reset = 1'b1;

        set_reg(1, 5);
        set_reg(2, 7);
        op(1, 1, 2, 3, 0, 0, 0, 1, 0, 0, 0, 0);
        run();
        mregs[3] = 32'hFFFFFFFE;
        check("sub_latency", lat, 2);
        check("sub_flags", {Zero, Neg, Carry}, 3'b010);
        read_reg(3, v);
        check("sub_rd3", v, 32'hFFFFFFFE);

        op(0, 0, 0, 0, 9, 1, 0, 1, 0, 0, 0, 0);
        run();
        check("addi_x0_latency", lat, 2);
        read_reg(0, v);
        check("addi_x0_value", v, 0);

        set_reg(2, 32'hDEADBEEF);
        set_reg(1, 32'h10);
        exp_addr = 30'h4; exp_wd = 32'hDEADBEEF; exp_we = 1;
        op(0, 1, 2, 0, 0, 1, 0, 0, 0, 1, 0, 0);
        ack_wait = 3;
        run();
        mmem[4] = 32'hDEADBEEF;
        check("st_latency", lat, 6);
        check("st_req_cycles", req_cycles, 4);
        check("st_bus_stable", {addr_bad, wd_bad, we_bad}, 0);
        check("st_no_err", err_seen, 0);
        check("st_mem", smem[4], 32'hDEADBEEF);

        exp_addr = 30'h4; exp_wd = 0; exp_we = 0;
        op(0, 1, 0, 6, 0, 1, 1, 1, 1, 0, 0, 0);
        ack_wait = 0;
        run();
        mregs[6] = mmem[4];
        check("ld_latency", lat, 3);
        check("ld_bus", {addr_bad, wd_bad, we_bad}, 0);
        read_reg(6, v);
        check("ld_rd6", v, mregs[6]);

        set_reg(5, 32'h12345678);
        op(0, 1, 0, 5, 3, 1, 1, 1, 1, 0, 0, 0);
        run();
        check("misal_no_req", req_cycles, 0);
        check("misal_err", err_seen, 1);
        check("misal_latency", lat, 2);
        read_reg(5, v);
        check("misal_rd5", v, 32'h12345678);

        exp_addr = 30'h6; exp_wd = 32'hDEADBEEF; exp_we = 1;
        op(0, 1, 2, 0, 8, 1, 0, 0, 1, 1, 0, 0);
        ack_wait = 1;
        run();
        mmem[6] = 32'hDEADBEEF;
        check("rdwr_is_store", {addr_bad, wd_bad, we_bad}, 0);
        check("rdwr_mem", smem[6], 32'hDEADBEEF);

        op(0, 1, 2, 0, 0, 1, 0, 0, 0, 1, 0, 0);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #1;
        check("abort_req_before", bus.mem_req, 1);
        #2 reset = 1'b0;
        #1;
        check("abort_req_low", bus.mem_req, 0);
        check("abort_busy", busy, 0);
        check("abort_bus", {bus.mem_we, bus.Address, bus.WriteData}, 0);
        check("abort_state", {done, err, Zero, Neg, Carry, PCReg}, 0);
        #1 reset = 1'b1;
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        set_reg(4, 32'hCAFE0001);
        check("post_reset_latency", lat, 2);
        read_reg(4, v);
        check("post_reset_rd4", v, 32'hCAFE0001);
        read_reg(2, v);
        check("post_reset_cleared", v, 0);

`ifdef DATAPATH_MUL_EN
        set_reg(1, 32'h0000FFFF);
        set_reg(2, 32'h00010001);
        op(10, 1, 2, 8, 0, 0, 0, 1, 0, 0, 0, 0);
        run();
        mregs[8] = 32'hFFFFFFFF;
        check("mul_latency", lat, NB + 2);
        check("mul_flags", {Zero, Neg, Carry}, 3'b010);
        read_reg(8, v);
        check("mul_rd8", v, 32'hFFFFFFFF);
`endif

        for (int n = 0; n < 60; n++) begin
            rs1 = $urandom_range(0, 31);
            rs2 = $urandom_range(0, 31);
            rd = $urandom_range(0, 31);
            if ($urandom_range(0, 9) < 7) begin
                code = $urandom_range(0, 15);
                asrc = 1'($urandom_range(0, 1));
                rw = 1'($urandom_range(0, 1));
                lk = $urandom_range(0, 4) == 0;
                imm = $urandom;
                pcl = $urandom;
                a = mregs[rs1];
                b = asrc ? imm : mregs[rs2];
                exp = ref_alu(code, a, b, c);
                op(4'(code), rs1, rs2, rd, imm, asrc, 0, rw, 0, 0, lk, pcl);
                ack_wait = 0;
                run();
                check($sformatf("rnd_latency_op%0d", code), lat, (MUL_ON && code == 10) ? NB + 2 : 2);
                check("rnd_srca", PCReg, a);
                check($sformatf("rnd_flags_op%0d", code), {Zero, Neg, Carry}, {exp == 0, exp[31], c});
                if (rw && rd != 0) mregs[rd] = lk ? pcl : exp;
            end else begin
                word = $urandom_range(0, 63);
                st = 1'($urandom_range(0, 1));
                imm = {word[29:0], 2'b00} - mregs[rs1];
                ack_wait = $urandom_range(0, 3);
                exp_addr = 30'(word);
                exp_wd = mregs[rs2];
                exp_we = st;
                if (st) op(0, rs1, rs2, 0, imm, 1, 0, 0, 0, 1, 0, 0);
                else    op(0, rs1, rs2, rd, imm, 1, 1, 1, 1, 0, 0, 0);
                run();
                check("rnd_mem_latency", lat, 3 + ack_wait);
                check("rnd_mem_req_cycles", req_cycles, ack_wait + 1);
                check("rnd_mem_bus", {addr_bad, wd_bad, we_bad}, 0);
                if (st) mmem[word] = mregs[rs2];
                else if (rd != 0) mregs[rd] = mmem[word];
            end
        end

        for (int r = 0; r < 32; r++) begin
            read_reg(r, v);
            check($sformatf("final_reg%0d", r), v, mregs[r]);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
